// File: rtl/rgb_to_yuv_converter.sv
// rtl/rgb_to_yuv_converter.sv - RGB888 to YUV converter, three time-shared Q16 multipliers
//
// Purpose: converts one unsigned 8-bit RGB pixel into clipped 8-bit Y/U/V.
// Each of the three multipliers (Y, U, V) is reused over R, G and B,
// so a pixel takes three cycles; back-to-back pixels stream at one per 3 cycles.
//
// Optional feature macro: RGB2YUV_DOWNSAMPLE_EN
//   undefined -> 4:4:4 output, UV_valid mirrors Y_valid
//   defined   -> 4:2:2 output, U/V averaged over each even/odd pixel pair
//
// Ports:
//   CLOCK_50_I       50 MHz clock, rising-edge active
//   resetn           asynchronous active-low reset
//   pixel_valid_in   upstream presents R_in/G_in/B_in
//   R_in/G_in/B_in   unsigned 8-bit components
//   pixel_ready_out  pixel accepted on this edge when also valid
//   Y_out/U_out/V_out registered clipped results, held between pulses
//   Y_valid          one-cycle pulse for a new Y_out
//   UV_valid         one-cycle pulse for new U_out/V_out
`timescale 1ns/1ps

module rgb_to_yuv_converter (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       pixel_valid_in,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic       pixel_ready_out,
  output logic [7:0] Y_out,
  output logic [7:0] U_out,
  output logic [7:0] V_out,
  output logic       Y_valid,
  output logic       UV_valid
);

  typedef enum logic [1:0] {S_IDLE, S_MR, S_MG, S_MB} state_t;

  localparam logic signed [31:0] CY_R =  32'sd16843;
  localparam logic signed [31:0] CY_G =  32'sd33030;
  localparam logic signed [31:0] CY_B =  32'sd6423;
  localparam logic signed [31:0] CU_R = -32'sd9699;
  localparam logic signed [31:0] CU_G = -32'sd19071;
  localparam logic signed [31:0] CU_B =  32'sd28770;
  localparam logic signed [31:0] CV_R =  32'sd28770;
  localparam logic signed [31:0] CV_G = -32'sd24117;
  localparam logic signed [31:0] CV_B = -32'sd4653;

  // Offset plus rounding constant, folded into the first (R) product.
  localparam logic signed [31:0] OFF_Y  = 32'sd1081344;  // (16<<16)  + 32768
  localparam logic signed [31:0] OFF_UV = 32'sd8421376;  // (128<<16) + 32768

  state_t state, next_state;

  logic              accept;
  logic [7:0]        r_reg, g_reg, b_reg;
  logic [7:0]        mul_op;
  logic signed [31:0] acc_y, acc_u, acc_v;
  logic signed [31:0] coef_y, coef_u, coef_v;
  logic signed [31:0] mul_y, mul_u, mul_v;
  logic signed [31:0] sum_y, sum_u, sum_v;
  logic [7:0]        clip_y, clip_u, clip_v;

`ifdef RGB2YUV_DOWNSAMPLE_EN
  logic              uv_odd;
  logic [7:0]        u_even, v_even;
  logic [8:0]        u_avg, v_avg;
`endif

  // Integer part of a Q16 accumulator, saturated to 0..255.
  function automatic logic [7:0] clip8(input logic signed [31:0] a);
    logic signed [15:0] ipart;
    ipart = a[31:16];
    if (ipart > 16'sd255)
      clip8 = 8'hFF;
    else if (ipart < 16'sd0)
      clip8 = 8'h00;
    else
      clip8 = a[23:16];
  endfunction

  // State register
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = accept ? S_MR : S_IDLE;
      S_MR:    next_state = S_MG;
      S_MG:    next_state = S_MB;
      S_MB:    next_state = accept ? S_MR : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: ready in IDLE and in the last multiply cycle, which
  // lets the next pixel start without a bubble.
  always_comb begin
    pixel_ready_out = (state == S_IDLE) || (state == S_MB);
  end

  assign accept = pixel_valid_in & pixel_ready_out;

  // Multiplier operand / coefficient select for the current phase.
  always_comb begin
    mul_op = b_reg;
    coef_y = CY_B;
    coef_u = CU_B;
    coef_v = CV_B;
    case (state)
      S_MR: begin
        mul_op = r_reg;
        coef_y = CY_R;
        coef_u = CU_R;
        coef_v = CV_R;
      end
      S_MG: begin
        mul_op = g_reg;
        coef_y = CY_G;
        coef_u = CU_G;
        coef_v = CV_G;
      end
      default: ;
    endcase
  end

  assign mul_y = coef_y * $signed({24'd0, mul_op});
  assign mul_u = coef_u * $signed({24'd0, mul_op});
  assign mul_v = coef_v * $signed({24'd0, mul_op});

  assign sum_y = acc_y + mul_y;
  assign sum_u = acc_u + mul_u;
  assign sum_v = acc_v + mul_v;

  assign clip_y = clip8(sum_y);
  assign clip_u = clip8(sum_u);
  assign clip_v = clip8(sum_v);

`ifdef RGB2YUV_DOWNSAMPLE_EN
  assign u_avg = {1'b0, u_even} + {1'b0, clip_u} + 9'd1;
  assign v_avg = {1'b0, v_even} + {1'b0, clip_v} + 9'd1;
`endif

  // Datapath: capture, accumulate, register results.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_reg    <= 8'd0;
      g_reg    <= 8'd0;
      b_reg    <= 8'd0;
      acc_y    <= 32'sd0;
      acc_u    <= 32'sd0;
      acc_v    <= 32'sd0;
      Y_out    <= 8'd0;
      U_out    <= 8'd0;
      V_out    <= 8'd0;
      Y_valid  <= 1'b0;
      UV_valid <= 1'b0;
`ifdef RGB2YUV_DOWNSAMPLE_EN
      uv_odd   <= 1'b0;
      u_even   <= 8'd0;
      v_even   <= 8'd0;
`endif
    end else begin
      Y_valid  <= 1'b0;
      UV_valid <= 1'b0;

      // In S_MB the old b_reg still feeds the multiplier on this edge,
      // so overwriting the captured pixel here is safe.
      if (accept) begin
        r_reg <= R_in;
        g_reg <= G_in;
        b_reg <= B_in;
      end

      case (state)
        S_MR: begin
          acc_y <= mul_y + OFF_Y;
          acc_u <= mul_u + OFF_UV;
          acc_v <= mul_v + OFF_UV;
        end
        S_MG: begin
          acc_y <= sum_y;
          acc_u <= sum_u;
          acc_v <= sum_v;
        end
        S_MB: begin
          acc_y   <= sum_y;
          acc_u   <= sum_u;
          acc_v   <= sum_v;
          Y_out   <= clip_y;
          Y_valid <= 1'b1;
`ifdef RGB2YUV_DOWNSAMPLE_EN
          uv_odd <= ~uv_odd;
          if (!uv_odd) begin
            u_even <= clip_u;
            v_even <= clip_v;
          end else begin
            U_out    <= u_avg[8:1];
            V_out    <= v_avg[8:1];
            UV_valid <= 1'b1;
          end
`else
          U_out    <= clip_u;
          V_out    <= clip_v;
          UV_valid <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// tb/tb_rgb_to_yuv_converter.sv - self-checking bench for rgb_to_yuv_converter
`timescale 1ns/1ps

module tb_rgb_to_yuv_converter;

  logic       CLOCK_50_I = 1'b0;
  logic       resetn = 1'b1;
  logic       pixel_valid_in = 1'b0;
  logic [7:0] R_in = 8'd0;
  logic [7:0] G_in = 8'd0;
  logic [7:0] B_in = 8'd0;
  logic       pixel_ready_out;
  logic [7:0] Y_out, U_out, V_out;
  logic       Y_valid, UV_valid;

  rgb_to_yuv_converter dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .pixel_valid_in  (pixel_valid_in),
    .R_in            (R_in),
    .G_in            (G_in),
    .B_in            (B_in),
    .pixel_ready_out (pixel_ready_out),
    .Y_out           (Y_out),
    .U_out           (U_out),
    .V_out           (V_out),
    .Y_valid         (Y_valid),
    .UV_valid        (UV_valid)
  );

  initial forever #10 CLOCK_50_I = ~CLOCK_50_I;

  int n_tests = 0;
  int n_fails = 0;
  int cyc = 0;
  int rst_epoch = 0;
  int y_override = -1;

  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion: exact integer arithmetic, floor by 65536, saturate.
  function automatic int sat8(input longint v);
    longint q;
    q = v >>> 16;
    if (q > 255) return 255;
    if (q < 0) return 0;
    return int'(q);
  endfunction

  function automatic void ref_yuv(input int r, input int g, input int b,
                                  output int y, output int u, output int v);
    y = sat8(longint'(16843) * r + longint'(33030) * g + longint'(6423) * b + 16 * 65536 + 32768);
    u = sat8(-longint'(9699) * r - longint'(19071) * g + longint'(28770) * b + 128 * 65536 + 32768);
    v = sat8(longint'(28770) * r - longint'(24117) * g - longint'(4653) * b + 128 * 65536 + 32768);
  endfunction

  typedef struct {
    int due;
    int y;
    int u;
    int v;
  } exp_t;

  exp_t q[$];

  // Compare process: model of acceptance, latency and output hold.
  int busy = 0;
  int seen_epoch = 0;
  int last_y = 0, last_u = 0, last_v = 0;
  int u_even = 0, v_even = 0;
  bit par = 0;

  always @(negedge CLOCK_50_I) begin
    exp_t e;
    bit   rdy_exp, due, uvv_exp;
    int   my, mu, mv;
    if (!resetn || rst_epoch != seen_epoch) begin
      q.delete();
      busy = 0;
      last_y = 0; last_u = 0; last_v = 0;
      u_even = 0; v_even = 0;
      par = 0;
      seen_epoch = rst_epoch;
    end
    if (resetn) begin
      rdy_exp = (busy == 0);
      chk("ready", int'(pixel_ready_out), int'(rdy_exp));
      if (busy > 0) busy--;
      due = (q.size() > 0) && (q[0].due == cyc);
      uvv_exp = 0;
      if (due) begin
        e = q.pop_front();
        last_y = e.y;
`ifdef RGB2YUV_DOWNSAMPLE_EN
        if (!par) begin
          u_even = e.u;
          v_even = e.v;
        end else begin
          last_u = (u_even + e.u + 1) >> 1;
          last_v = (v_even + e.v + 1) >> 1;
          uvv_exp = 1;
        end
        par = !par;
`else
        last_u = e.u;
        last_v = e.v;
        uvv_exp = 1;
`endif
      end
      chk("y_valid", int'(Y_valid), int'(due));
      chk("uv_valid", int'(UV_valid), int'(uvv_exp));
      chk("y_out", int'(Y_out), last_y);
      chk("u_out", int'(U_out), last_u);
      chk("v_out", int'(V_out), last_v);
      if (pixel_valid_in && rdy_exp) begin
        ref_yuv(int'(R_in), int'(G_in), int'(B_in), my, mu, mv);
        if (y_override >= 0) my = y_override;
        e.due = cyc + 4;
        e.y = my; e.u = mu; e.v = mv;
        q.push_back(e);
        busy = 2;
      end
    end
  end

  task automatic send(input int r, input int g, input int b);
    bit ok;
    ok = 0;
    R_in = 8'(r); G_in = 8'(g); B_in = 8'(b);
    pixel_valid_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK_50_I);
      if (pixel_ready_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_accept_timeout", 0, 1);
    @(posedge CLOCK_50_I);
    #1;
    pixel_valid_in = 1'b0;
  endtask

  task automatic wait_y(output int y, output int u, output int v, output int uvv, output int at);
    bit ok;
    ok = 0;
    y = -1; u = -1; v = -1; uvv = -1; at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50_I);
      if (Y_valid) begin
        y = int'(Y_out); u = int'(U_out); v = int'(V_out);
        uvv = int'(UV_valid); at = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) chk("y_valid_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    rst_epoch++;
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    int y, u, v, uvv, at, t0, uvv_red;

    // Reset state
    #1 resetn = 1'b0;
    #4;
    chk("rst_y", int'(Y_out), 0);
    chk("rst_u", int'(U_out), 0);
    chk("rst_v", int'(V_out), 0);
    chk("rst_yvalid", int'(Y_valid), 0);
    chk("rst_uvvalid", int'(UV_valid), 0);
    chk("rst_ready", int'(pixel_ready_out), 1);
    @(negedge CLOCK_50_I);
    #2 resetn = 1'b1;
    @(posedge CLOCK_50_I);
    #1 chk("ready_after_release", int'(pixel_ready_out), 1);

    // Model pins
    ref_yuv(0, 0, 0, y, u, v);
    chk("model_black_y", y, 16); chk("model_black_u", u, 128); chk("model_black_v", v, 128);
    ref_yuv(255, 255, 255, y, u, v);
    chk("model_white_y", y, 235); chk("model_white_u", u, 128); chk("model_white_v", v, 128);
    ref_yuv(255, 0, 0, y, u, v);
    chk("model_red_y", y, 82); chk("model_red_u", u, 90); chk("model_red_v", v, 240);

    // Single black pixel, latency 3
    send(0, 0, 0);
    t0 = cyc;
    wait_y(y, u, v, uvv, at);
    chk("black_y", y, 16);
    chk("latency_black", at - t0, 3);
`ifndef RGB2YUV_DOWNSAMPLE_EN
    chk("black_u", u, 128);
    chk("black_v", v, 128);
    chk("black_uvvalid", uvv, 1);
`else
    chk("black_uvvalid_even", uvv, 0);
`endif
    repeat (3) @(posedge CLOCK_50_I);
    #1;

    // Back-to-back stream, valid held high throughout
    send(255, 255, 255);
    send(255, 0, 0);
    send(12, 200, 77);
    send(0, 90, 255);
    repeat (12) @(posedge CLOCK_50_I);
    #1 chk("stream_drained", q.size(), 0);

    // Reset during S_MG discards the pixel
    send(255, 0, 0);
    @(posedge CLOCK_50_I);
    #2 resetn = 1'b0;
    rst_epoch++;
    #1;
    chk("midrst_y", int'(Y_out), 0);
    chk("midrst_u", int'(U_out), 0);
    chk("midrst_v", int'(V_out), 0);
    chk("midrst_yvalid", int'(Y_valid), 0);
    chk("midrst_ready", int'(pixel_ready_out), 1);
    #2 resetn = 1'b1;
    repeat (6) @(posedge CLOCK_50_I);
    #1;
    send(255, 255, 255);
    t0 = cyc;
    wait_y(y, u, v, uvv, at);
    chk("after_rst_y", y, 235);
    chk("latency_after_rst", at - t0, 3);
    repeat (3) @(posedge CLOCK_50_I);
    #1;

    // Clipping through forced accumulator
    y_override = 0;
    force dut.acc_y = -32'sd65536;
    send(0, 0, 0);
    wait_y(y, u, v, uvv, at);
    chk("clip_low_y", y, 0);
    release dut.acc_y;
    repeat (2) @(posedge CLOCK_50_I);
    #1;
    y_override = 255;
    force dut.acc_y = 32'sd19660800;
    send(0, 0, 0);
    wait_y(y, u, v, uvv, at);
    chk("clip_high_y", y, 255);
    release dut.acc_y;
    y_override = -1;
    repeat (3) @(posedge CLOCK_50_I);
    #1;

    // Red then white after a fresh reset (pair parity even)
    pulse_reset();
    repeat (2) @(posedge CLOCK_50_I);
    #1;
    send(255, 0, 0);
    wait_y(y, u, v, uvv, at);
    uvv_red = uvv;
    chk("red_y", y, 82);
`ifndef RGB2YUV_DOWNSAMPLE_EN
    chk("red_u", u, 90);
    chk("red_v", v, 240);
    chk("red_uvvalid", uvv_red, 1);
`else
    chk("red_uvvalid_even", uvv_red, 0);
`endif
    send(255, 255, 255);
    wait_y(y, u, v, uvv, at);
    chk("white_y", y, 235);
`ifdef RGB2YUV_DOWNSAMPLE_EN
    chk("pair_u", u, 109);
    chk("pair_v", v, 184);
`else
    chk("white_u", u, 128);
    chk("white_v", v, 128);
`endif
    chk("white_uvvalid", uvv, 1);

    repeat (5) @(posedge CLOCK_50_I);
    #1 chk("final_pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_to_yuv_converter.md
RGB_TO_YUV_CONVERTER -- requirements
Module: rgb_to_yuv_converter

Interface
REQ-001 SHALL have port CLOCK_50_I, input, 1 bit: 50 MHz clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pixel_valid_in, input, 1 bit: an RGB pixel is presented.
REQ-004 SHALL have port R_in, G_in, B_in, input, 8 bits each: unsigned pixel components.
REQ-005 SHALL have port pixel_ready_out, output, 1 bit: the block accepts a pixel on this edge.
REQ-006 SHALL have port Y_out, U_out, V_out, output, 8 bits each: clipped results, all registered.
REQ-007 SHALL have port Y_valid, output, 1 bit: one-cycle pulse marking a new Y_out.
REQ-008 SHALL have port UV_valid, output, 1 bit: one-cycle pulse marking new U_out/V_out.

Function
REQ-009 SHALL compute, in Q16 fixed point: Y = 16843R + 33030G + 6423B + (16<<16); U = -9699R - 19071G + 28770B + (128<<16); V = 28770R - 24117G - 4653B + (128<<16). Each sum SHALL add the rounding constant 32768.
REQ-010 SHALL use exactly three 32-bit signed multipliers, one each for Y, U and V, time-shared over R, G and B.
REQ-011 SHALL implement FSM states S_IDLE, S_MR, S_MG and S_MB; reset state is S_IDLE.
REQ-012 SHALL drive pixel_ready_out = 1 in S_IDLE and in S_MB, and 0 in every other state.
REQ-013 On an edge where pixel_valid_in & pixel_ready_out, SHALL capture R_in/G_in/B_in into internal registers and enter S_MR.
REQ-014 S_MR SHALL load each accumulator with coef_R*R + offset + 32768, then enter S_MG; S_MG SHALL add coef_G*G, then enter S_MB.
REQ-015 S_MB SHALL add coef_B*B and register the clipped results. It SHALL then enter S_MR if a new pixel was accepted on that edge, otherwise S_IDLE.
REQ-016 Clipping rule: acc[31:16] (signed) > 255 SHALL give 255; < 0 SHALL give 0; otherwise the output SHALL be acc[23:16].
REQ-017 Latency: for a pixel accepted at edge E0, outputs and Y_valid SHALL update at edge E0+3 and Y_valid SHALL be high for exactly one cycle.
REQ-018 Back-to-back throughput SHALL be one pixel per 3 cycles, with no bubble.
REQ-019 Once a pixel is accepted, deasserting pixel_valid_in SHALL NOT abort it; the pixel SHALL complete.
REQ-020 pixel_valid_in asserted while pixel_ready_out = 0 SHALL be ignored; the upstream holds the data.
REQ-021 Y_out/U_out/V_out SHALL hold their last values between valid pulses.

Reset
REQ-022 When resetn = 0, SHALL immediately force: state S_IDLE; accumulators, captured RGB and all outputs to 0; Y_valid = UV_valid = 0; pair parity = even.
REQ-023 A reset asserted mid-pixel SHALL discard that pixel; no valid pulse SHALL occur for it after release.
REQ-024 pixel_ready_out SHALL be 1 during reset and on the first cycle after release.

Configuration
REQ-025 Macro RGB2YUV_DOWNSAMPLE_EN, undefined: UV_valid SHALL equal Y_valid for every pixel (4:4:4 output).
REQ-026 Macro RGB2YUV_DOWNSAMPLE_EN, defined, 4:2:2 output:
- pair parity SHALL toggle at every Y_valid.
- on an even pixel, SHALL store its clipped U/V internally, leave U_out/V_out unchanged and hold UV_valid at 0.
- on an odd pixel, SHALL output U_out = (U_even + U_odd + 1) >> 1 (same for V) with a 9-bit intermediate, and pulse UV_valid together with Y_valid.
REQ-027 Reset SHALL clear the stored even-pixel U/V when RGB2YUV_DOWNSAMPLE_EN is defined.

Verification
REQ-028 Single pixel, R=G=B=0, accepted at edge E0 -> Y=16, U=128, V=128; Y_valid and UV_valid pulse at E0+3 only.
REQ-029 R=G=B=255 -> Y=235, U=128, V=128; R=255, G=B=0 -> Y=82, U=90, V=240.
REQ-030 Four pixels with pixel_valid_in held high -> pixel_ready_out pattern 1,0,0,1,0,0,...; Y_valid every 3rd cycle; no pixel lost or duplicated.
REQ-031 resetn pulsed low at S_MG of a pixel -> outputs 0 immediately; no Y_valid for that pixel; the next pixel completes normally with latency 3.
REQ-032 With RGB2YUV_DOWNSAMPLE_EN, input red (U=90, V=240) then white (U=128, V=128) -> UV_valid low on the first pixel; on the second, U_out=109, V_out=184 with UV_valid high.
REQ-033 Clip check: force accumulators (bench override) to -65536 and to 300<<16 -> output 0 and 255 respectively.
